// File: rtl/i2s_receiver.sv
// i2s_receiver
//   Captures the codec's I2S ADC stream into parallel stereo frames in the
//   Clk domain. SCLK, LRCLK and SDIN are asynchronous and are sampled
//   through synchronisers, so Clk must run at least 8x the SCLK rate.
//   A frame is only presented when a left word is followed by a right word
//   of the same frame.
//
// Ports
//   Clk          system clock (50 MHz)
//   Reset        synchronous, active-high
//   SCLK         codec bit clock (async)
//   LRCLK        codec word clock, 0 = left, 1 = right (async)
//   SDIN         codec ADC serial data, MSB first (async)
//   left_out     left sample of the presented frame
//   right_out    right sample of the presented frame
//   valid        frame available on left_out/right_out
//   ready        consumer accepts the frame
//   overrun      sticky: a frame was overwritten before being consumed
//   slot_err     sticky: a slot ended before SAMPLE_WIDTH bits were captured
//   clear_flags  one-cycle pulse clearing overrun and slot_err
//
// State table
//   state    | meaning
//   ST_SYNC    | waiting for the first slot boundary; all bits ignored
//   ST_CAPTURE | shifting in sample bits of the current slot
//   ST_PAD     | word done (or discarded); ignore bits until next boundary
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    SCLK,
  input  logic                    LRCLK,
  input  logic                    SDIN,
  output logic [SAMPLE_WIDTH-1:0] left_out,
  output logic [SAMPLE_WIDTH-1:0] right_out,
  output logic                    valid,
  input  logic                    ready,
  output logic                    overrun,
  output logic                    slot_err,
  input  logic                    clear_flags
);

  localparam int CNT_W = $clog2(SLOT_WIDTH);

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_PAD     = 2'd2;

  logic sclk_meta, sclk_sync, sclk_dly;
  logic lr_meta, lr_s;
  logic sd_meta, sd_s;

  logic [1:0]              state;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    slot_ch;
  // The final bit of a word is taken straight from sd_s, so the register
  // only needs to hold the first SAMPLE_WIDTH-1 bits.
  logic [SAMPLE_WIDTH-2:0] shift_reg;
  logic [SAMPLE_WIDTH-1:0] left_hold;
  logic                    left_ok;
  logic                    lr_prev;
  logic                    prev_seen;

  logic                    bit_event;
  logic                    boundary;
  logic                    word_done;
  logic                    frame_done;
  logic                    short_slot;
  logic [SAMPLE_WIDTH-1:0] word_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_dly  <= 1'b0;
      lr_meta   <= 1'b0;
      lr_s      <= 1'b0;
      sd_meta   <= 1'b0;
      sd_s      <= 1'b0;
    end else begin
      sclk_meta <= SCLK;
      sclk_sync <= sclk_meta;
      sclk_dly  <= sclk_sync;
      lr_meta   <= LRCLK;
      lr_s      <= lr_meta;
      sd_meta   <= SDIN;
      sd_s      <= sd_meta;
    end
  end

  assign bit_event = sclk_sync & ~sclk_dly;
  // The first bit event after reset has no valid lr_prev to compare with;
  // treating it as a boundary would start capture in the middle of a slot.
  assign boundary   = bit_event & prev_seen & (lr_s != lr_prev);
  assign word_next  = {shift_reg, sd_s};
  assign word_done  = bit_event & ~boundary & (state == ST_CAPTURE) &
                      (bit_cnt == CNT_W'(SAMPLE_WIDTH - 1));
  assign frame_done = word_done & slot_ch & left_ok;
  assign short_slot = boundary & (state == ST_CAPTURE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_SYNC;
      bit_cnt   <= '0;
      slot_ch   <= 1'b0;
      shift_reg <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      lr_prev   <= 1'b0;
      prev_seen <= 1'b0;
    end else if (bit_event) begin
      lr_prev   <= lr_s;
      prev_seen <= 1'b1;
      if (boundary) begin
        // The boundary bit is the previous slot's LSB and is dropped.
        bit_cnt   <= '0;
        slot_ch   <= lr_s;
        shift_reg <= '0;
        state     <= ST_CAPTURE;
        if (!lr_s || state == ST_CAPTURE)
          left_ok <= 1'b0;
      end else begin
        case (state)
          ST_SYNC: begin
          end
          ST_CAPTURE: begin
            shift_reg <= word_next[SAMPLE_WIDTH-2:0];
            bit_cnt   <= bit_cnt + 1'b1;
            if (word_done) begin
              state <= ST_PAD;
              if (!slot_ch) begin
                left_hold <= word_next;
                left_ok   <= 1'b1;
              end else begin
                left_ok <= 1'b0;
              end
            end
          end
          ST_PAD: begin
            if (bit_cnt != CNT_W'(SLOT_WIDTH - 1))
              bit_cnt <= bit_cnt + 1'b1;
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      left_out  <= '0;
      right_out <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      slot_err  <= 1'b0;
    end else begin
      if (valid && ready)
        valid <= 1'b0;
      if (frame_done) begin
        left_out  <= left_hold;
        right_out <= word_next;
        valid     <= 1'b1;
      end
      // Clear first so that a set on the same cycle wins.
      if (clear_flags) begin
        overrun  <= 1'b0;
        slot_err <= 1'b0;
      end
      if (frame_done && valid && !ready)
        overrun <= 1'b1;
      if (short_slot)
        slot_err <= 1'b1;
    end
  end

endmodule
